// File: rtl/sysa_result_collector.sv
// sysa_result_collector
// Captures the skewed column outputs of the 3x3 systolic array, deskews them
// into a row-major 9-entry result buffer and drains the buffer as five packed
// 32-bit words over a valid/ready read port. Single clock domain.
// The buffer is never cleared between runs; every entry is rewritten by a
// full capture, so stale data cannot leak into a completed result.

module sysa_result_collector #(
    parameter int DW = 16,
    parameter int OW = 32,
    parameter int N  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] out1,
    input  logic [DW-1:0] out2,
    input  logic [DW-1:0] out3,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [OW-1:0] rd_data,
    output logic          rd_last,
    output logic          done,
    output logic          start_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    // Last capture beat and last readout word share the same index.
    localparam logic [2:0] LAST_IDX = 3'd4;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [2:0]                  r_step;
    logic [2:0]                  w_step_next;
    logic [2:0]                  r_wptr;
    logic [2:0]                  w_wptr_next;
    logic [N*N-1:0][DW-1:0]      r_buf;
    logic [N*N-1:0][DW-1:0]      w_buf_next;
    logic                        w_accept;

    logic                        r_rd_valid;
    logic                        r_rd_last;
    logic [OW-1:0]               r_rd_data;
    logic                        r_done;
    logic                        r_start_err;

    // Pack two consecutive buffer entries into one readout word; word 4 holds
    // only the last entry, zero-extended in the upper half.
    function automatic logic [OW-1:0] pack_word(
        input logic [N*N-1:0][DW-1:0] b,
        input logic [2:0]             w
    );
        logic [OW-1:0] word;
        case (w)
            3'd0:    word = {b[1], b[0]};
            3'd1:    word = {b[3], b[2]};
            3'd2:    word = {b[5], b[4]};
            3'd3:    word = {b[7], b[6]};
            3'd4:    word = {{(OW-DW){1'b0}}, b[8]};
            default: word = {OW{1'b0}};
        endcase
        return word;
    endfunction

    // Next-state, next-pointer and deskewing buffer writes for the collector FSM.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_wptr_next  = r_wptr;
        w_buf_next   = r_buf;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CAPTURE;
                    w_step_next  = 3'd0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    // Column j carries row (step-j) on this beat: buf[row*3+j].
                    case (r_step)
                        3'd0: begin
                            w_buf_next[0] = out1;
                        end
                        3'd1: begin
                            w_buf_next[3] = out1;
                            w_buf_next[1] = out2;
                        end
                        3'd2: begin
                            w_buf_next[6] = out1;
                            w_buf_next[4] = out2;
                            w_buf_next[2] = out3;
                        end
                        3'd3: begin
                            w_buf_next[7] = out2;
                            w_buf_next[5] = out3;
                        end
                        3'd4: begin
                            w_buf_next[8] = out3;
                        end
                        default: begin
                            w_buf_next = r_buf;
                        end
                    endcase
                    if (r_step == LAST_IDX) begin
                        w_state_next = S_DRAIN;
                        w_wptr_next  = 3'd0;
                    end else begin
                        w_step_next = r_step + 3'd1;
                    end
                end else begin
                    w_step_next = r_step;
                end
            end
            S_DRAIN: begin
                w_accept = r_rd_valid & rd_ready;
                if (w_accept) begin
                    if (r_wptr == LAST_IDX) begin
                        w_state_next = S_IDLE;
                        w_wptr_next  = 3'd0;
                    end else begin
                        w_wptr_next = r_wptr + 3'd1;
                    end
                end else begin
                    w_wptr_next = r_wptr;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, buffer and registered read-port outputs; outputs are computed
    // from next-state values so the first word appears the cycle after beat 4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_step      <= 3'd0;
            r_wptr      <= 3'd0;
            r_buf       <= {(N*N*DW){1'b0}};
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= {OW{1'b0}};
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_step      <= w_step_next;
            r_wptr      <= w_wptr_next;
            r_buf       <= w_buf_next;
            r_rd_valid  <= (w_state_next == S_DRAIN);
            r_rd_last   <= (w_state_next == S_DRAIN) && (w_wptr_next == LAST_IDX);
            r_rd_data   <= (w_state_next == S_DRAIN) ? pack_word(w_buf_next, w_wptr_next)
                                                     : {OW{1'b0}};
            r_done      <= w_accept && (r_wptr == LAST_IDX);
            r_start_err <= start && (r_state != S_IDLE);
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign start_err = r_start_err;

endmodule

// File: tb/tb_sysa_result_collector.sv
// Directed testbench for sysa_result_collector: capture/drain, gaps,
// backpressure, illegal start, reset mid-drain and ignored traffic.

module tb_sysa_result_collector;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [15:0] out1;
    logic [15:0] out2;
    logic [15:0] out3;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        done;
    logic        start_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_w [5];

    sysa_result_collector #(.DW(16), .OW(32), .N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .start_err (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks = n_checks + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // start then five beats; out_j = base_j (+k when inc), optional gaps and an illegal start
    task automatic capture(input logic [15:0] b1, input logic [15:0] b2, input logic [15:0] b3,
                           input bit inc, input int gap, input bit bad_start);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ok_no_err", {31'd0, start_err}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            out1 = inc ? b1 + 16'(k) : b1;
            out2 = inc ? b2 + 16'(k) : b2;
            out3 = inc ? b3 + 16'(k) : b3;
            tick();
            in_valid = 1'b0;
            out1 = 16'hDEAD; out2 = 16'hDEAD; out3 = 16'hDEAD;
            if (k < 4) begin
                check("cap_valid_low", {31'd0, rd_valid}, 32'd0);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("gap_valid_low", {31'd0, rd_valid}, 32'd0);
                end
                if (bad_start && k == 1) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    check("cap_start_err", {31'd0, start_err}, 32'd1);
                    tick();
                    check("cap_start_err_clr", {31'd0, start_err}, 32'd0);
                end
            end
        end
        check("valid_after_beat4", {31'd0, rd_valid}, 32'd1);
    endtask

    // drain all five words, optionally stalling on one word and pulsing start
    task automatic drain(input int hold_w, input int hold_n, input bit bad_start);
        for (int w = 0; w < 5; w++) begin
            if (w == hold_w) begin
                rd_ready = 1'b0;
                for (int h = 0; h < hold_n; h++) begin
                    start = bad_start && (h == 0);
                    tick();
                    start = 1'b0;
                    if (bad_start && h == 0)
                        check("drain_start_err", {31'd0, start_err}, 32'd1);
                    check("hold_data", rd_data, exp_w[w]);
                    check("hold_valid", {31'd0, rd_valid}, 32'd1);
                end
            end
            rd_ready = 1'b1;
            check("word_data", rd_data, exp_w[w]);
            check("word_last", {31'd0, rd_last}, (w == 4) ? 32'd1 : 32'd0);
            check("word_valid", {31'd0, rd_valid}, 32'd1);
            check("word_no_done", {31'd0, done}, 32'd0);
            tick();
        end
        rd_ready = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("valid_off", {31'd0, rd_valid}, 32'd0);
        tick();
        check("done_clear", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; rd_ready = 1'b0;
        out1 = 16'd0; out2 = 16'd0; out3 = 16'd0;
        exp_w[0] = 32'h02010100;
        exp_w[1] = 32'h01010302;
        exp_w[2] = 32'h03030202;
        exp_w[3] = 32'h02030102;
        exp_w[4] = 32'h00000304;

        // reset state
        tick(); tick();
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_last", {31'd0, rd_last}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, start_err}, 32'd0);
        check("rst_data", rd_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic capture and drain
        capture(16'h0100, 16'h0200, 16'h0300, 1'b1, 0, 1'b0);
        drain(-1, 0, 1'b0);

        // gaps between beats
        capture(16'h0100, 16'h0200, 16'h0300, 1'b1, 2, 1'b0);
        drain(-1, 0, 1'b0);

        // backpressure on word 2
        capture(16'h0100, 16'h0200, 16'h0300, 1'b1, 0, 1'b0);
        drain(2, 7, 1'b0);

        // illegal start during capture and during drain
        capture(16'h0100, 16'h0200, 16'h0300, 1'b1, 1, 1'b1);
        drain(1, 3, 1'b1);

        // reset after word 1 accepted
        capture(16'h0100, 16'h0200, 16'h0300, 1'b1, 0, 1'b0);
        rd_ready = 1'b1;
        tick(); tick();
        rd_ready = 1'b0;
        check("pre_rst_data", rd_data, exp_w[2]);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_valid", {31'd0, rd_valid}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_data", rd_data, 32'd0);
        tick();
        check("mrst_idle_valid", {31'd0, rd_valid}, 32'd0);
        exp_w[0] = 32'hFFFFFFFF; exp_w[1] = 32'hFFFFFFFF;
        exp_w[2] = 32'hFFFFFFFF; exp_w[3] = 32'hFFFFFFFF;
        exp_w[4] = 32'h0000FFFF;
        capture(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);
        drain(-1, 0, 1'b0);

        // ignored traffic in IDLE
        in_valid = 1'b1; out1 = 16'hAAAA; out2 = 16'hAAAA; out3 = 16'hAAAA;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("idle_beat_valid", {31'd0, rd_valid}, 32'd0);
        end
        in_valid = 1'b0;
        exp_w[0] = 32'h02010100;
        exp_w[1] = 32'h01010302;
        exp_w[2] = 32'h03030202;
        exp_w[3] = 32'h02030102;
        exp_w[4] = 32'h00000304;
        capture(16'h0100, 16'h0200, 16'h0300, 1'b1, 0, 1'b0);

        // ignored traffic in DRAIN
        in_valid = 1'b1; out1 = 16'h5555; out2 = 16'h5555; out3 = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_beat_data", rd_data, exp_w[0]);
            check("drain_beat_valid", {31'd0, rd_valid}, 32'd1);
        end
        in_valid = 1'b0;
        drain(-1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
